mmio_parallel_io: RTL and testbench

- Parametrised memory-mapped parallel I/O controller on the CPU data bus, between the ALU address/rd2 write data and the data RAM.
- Generalises the fixed single-port input/output pair to N_IN input and N_OUT output channels of DATA_W bits.
- Adds input synchronisation and debouncing, change-capture status with write-1-to-clear, and RAM write-enable gating for the I/O region.

---
 rtl/mmio_pio_pkg.sv | 12 +
 rtl/pio_in_debounce.sv | 53 +++++
 rtl/mmio_parallel_io.sv | 121 ++++++++++++
 tb/tb_mmio_parallel_io.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pio_pkg.sv
// rtl/mmio_pio_pkg.sv - register offsets and limits shared by mmio_parallel_io and its sub-modules
package mmio_pio_pkg;

    localparam logic [3:0] OFS_IN0    = 4'd0;
    localparam logic [3:0] OFS_OUT0   = 4'd4;
    localparam logic [3:0] OFS_STATUS = 4'd8;
    localparam logic [3:0] OFS_MASK   = 4'd9;

    localparam int REGION_SPAN = 16;
    localparam int MAX_CH      = 4;

endpackage

// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - one input channel: 2-FF synchroniser, debounce counter, stable value, change pulse
module pio_in_debounce #(
    parameter int DATA_W       = 8,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] stable,
    output logic              change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DATA_W-1:0] sync1_q, sync1_d;
    logic [DATA_W-1:0] sync2_q, sync2_d;
    logic [DATA_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // sync1 != sync2 means the synchronised value is about to change, which restarts the count
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        change   = 1'b0;
        if ((sync1_q == sync2_q) && (sync2_q != stable_q)) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_d = sync2_q;
                change   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/mmio_parallel_io.sv
// rtl/mmio_parallel_io.sv - memory-mapped parallel I/O controller; MMIO_PIO_IRQ_EN adds the irq mask register
module mmio_parallel_io
    import mmio_pio_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 8'hF0,
    parameter int                N_IN         = 2,
    parameter int                N_OUT        = 2,
    parameter int                DEBOUNCE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    we,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ram_we,
    input  logic [N_IN*DATA_W-1:0]  din,
    output logic [N_OUT*DATA_W-1:0] dout,
    output logic                    irq
);

    logic                    in_region;
    logic [3:0]              off;
    logic                    wr_en;
    logic [N_IN*DATA_W-1:0]  stable_all;
    logic [N_IN-1:0]         change;
    logic [N_OUT*DATA_W-1:0] dout_q, dout_d;
    logic [N_IN-1:0]         status_q, status_d;

    assign in_region = (addr & ~ADDR_W'(REGION_SPAN - 1)) == BASE_ADDR;
    assign off       = addr[3:0];
    assign wr_en     = we & in_region;
    assign ram_we    = we & ~in_region;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        pio_in_debounce #(
            .DATA_W      (DATA_W),
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .din   (din[i*DATA_W +: DATA_W]),
            .stable(stable_all[i*DATA_W +: DATA_W]),
            .change(change[i])
        );
    end

    always_comb begin
        dout_d = dout_q;
        for (int j = 0; j < N_OUT; j++) begin
            if (wr_en && (off == OFS_OUT0 + 4'(j))) begin
                dout_d[j*DATA_W +: DATA_W] = wdata;
            end
        end
    end

    // a change pulse landing with a W1C write still sets its bit
    always_comb begin
        status_d = status_q;
        if (wr_en && (off == OFS_STATUS)) begin
            status_d = status_q & ~wdata[N_IN-1:0];
        end
        status_d = status_d | change;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q   <= '0;
            status_q <= '0;
        end else begin
            dout_q   <= dout_d;
            status_q <= status_d;
        end
    end

`ifdef MMIO_PIO_IRQ_EN
    logic [N_IN-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (off == OFS_MASK)) begin
            mask_d = wdata[N_IN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign irq = |(status_q & mask_q);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = mem_rdata;
        if (in_region) begin
            rdata = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (off == OFS_IN0 + 4'(i)) rdata = stable_all[i*DATA_W +: DATA_W];
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (off == OFS_OUT0 + 4'(j)) rdata = dout_q[j*DATA_W +: DATA_W];
            end
            if (off == OFS_STATUS) rdata = DATA_W'(status_q);
`ifdef MMIO_PIO_IRQ_EN
            if (off == OFS_MASK) rdata = DATA_W'(mask_q);
`endif
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_mmio_parallel_io.sv
// tb/tb_mmio_parallel_io.sv - self-checking bench for mmio_parallel_io (vector table, corner sequences, random vs model)
module tb_mmio_parallel_io;

    localparam int DEB = 4;

    logic        clk, rst;
    logic [7:0]  addr, wdata, mem_rdata, rdata;
    logic        we, ram_we, irq;
    logic [15:0] din, dout;

    int checks = 0;
    int failures = 0;

    mmio_parallel_io dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .mem_rdata(mem_rdata), .rdata(rdata), .ram_we(ram_we),
        .din(din), .dout(dout), .irq(irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // reference model: an input is accepted once the last DEB+1 samples agree and differ from stable
    logic [7:0] hist [2][DEB+1];
    logic [7:0] stable_m [2];
    logic [7:0] dout_m [2];
    logic [1:0] status_m, mask_m, m_pulse;
    bit         m_same;

    function automatic bit is_region(input logic [7:0] a);
        return a[7:4] == 4'hF;
    endfunction

    function automatic logic exp_irq();
`ifdef MMIO_PIO_IRQ_EN
        return |(status_m & mask_m);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] m_rdata(input logic [7:0] a, input logic [7:0] mr);
        if (!is_region(a)) return mr;
        case (a[3:0])
            4'd0: return stable_m[0];
            4'd1: return stable_m[1];
            4'd4: return dout_m[0];
            4'd5: return dout_m[1];
            4'd8: return {6'b0, status_m};
`ifdef MMIO_PIO_IRQ_EN
            4'd9: return {6'b0, mask_m};
`endif
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                stable_m[c] = 8'h00;
                dout_m[c]   = 8'h00;
                for (int k = 0; k <= DEB; k++) hist[c][k] = 8'h00;
            end
            status_m = 2'b00;
            mask_m   = 2'b00;
        end else begin
            m_pulse = 2'b00;
            for (int c = 0; c < 2; c++) begin
                m_same = 1'b1;
                for (int k = 1; k <= DEB; k++) if (hist[c][k] != hist[c][0]) m_same = 1'b0;
                if (m_same && hist[c][0] != stable_m[c]) begin
                    stable_m[c] = hist[c][0];
                    m_pulse[c]  = 1'b1;
                end
                for (int k = DEB; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = din[c*8 +: 8];
            end
            if (we && is_region(addr)) begin
                case (addr[3:0])
                    4'd4: dout_m[0] = wdata;
                    4'd5: dout_m[1] = wdata;
                    4'd8: status_m = status_m & ~wdata[1:0];
                    4'd9: mask_m = wdata[1:0];
                    default: ;
                endcase
            end
            status_m = status_m | m_pulse;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic check_all();
        chk("rnd_dout", dout, {dout_m[1], dout_m[0]});
        chk("rnd_irq", irq, exp_irq());
        chk("rnd_ram_we", ram_we, we && !is_region(addr));
        chk("rnd_rdata", rdata, m_rdata(addr, mem_rdata));
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  mem_rdata;
        logic [7:0]  exp_rdata;
        logic        exp_ram_we;
        logic [15:0] exp_dout;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{8'hF4, 1'b1, 8'hA5, 8'h11, 8'h00, 1'b0, 16'h0000};
        vecs[1]  = '{8'hF4, 1'b0, 8'h00, 8'h11, 8'hA5, 1'b0, 16'h00A5};
        vecs[2]  = '{8'h10, 1'b1, 8'h3C, 8'h77, 8'h77, 1'b1, 16'h00A5};
        vecs[3]  = '{8'h10, 1'b0, 8'h00, 8'h77, 8'h77, 1'b0, 16'h00A5};
        vecs[4]  = '{8'hFC, 1'b1, 8'h99, 8'h22, 8'h00, 1'b0, 16'h00A5};
        vecs[5]  = '{8'hFC, 1'b0, 8'h00, 8'h22, 8'h00, 1'b0, 16'h00A5};
        vecs[6]  = '{8'hF5, 1'b1, 8'hC3, 8'h00, 8'h00, 1'b0, 16'h00A5};
        vecs[7]  = '{8'hF5, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 16'hC3A5};
        vecs[8]  = '{8'hF0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 16'hC3A5};
        vecs[9]  = '{8'hF0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'hC3A5};
        vecs[10] = '{8'hEF, 1'b1, 8'h12, 8'h44, 8'h44, 1'b1, 16'hC3A5};
        vecs[11] = '{8'hF9, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'hC3A5};
        vecs[12] = '{8'hF8, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 16'hC3A5};
        vecs[13] = '{8'h00, 1'b0, 8'h00, 8'h5A, 8'h5A, 1'b0, 16'hC3A5};

        rst = 1'b0; addr = 8'h00; we = 1'b0; wdata = 8'h00; mem_rdata = 8'h00; din = 16'h0000;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_dout", dout, 16'h0000);
        chk("reset_irq", irq, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata; mem_rdata = vecs[i].mem_rdata;
            #2;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_ram_we);
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
        end

        @(negedge clk);
        we = 1'b0; addr = 8'hF0; din[7:0] = 8'h5A;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            #2 chk($sformatf("debounce_edge%0d", e), rdata, (e < 6) ? 8'h00 : 8'h5A);
        end
        rd_chk("debounce_status", 8'hF8, 8'h01);

        @(negedge clk);
        addr = 8'hF1; din[15:8] = 8'hFF;
        repeat (3) @(negedge clk);
        din[15:8] = 8'h00;
        repeat (10) @(negedge clk);
        rd_chk("glitch_in1", 8'hF1, 8'h00);
        rd_chk("glitch_status", 8'hF8, 8'h01);

        @(negedge clk);
        din[15:8] = 8'h33;
        repeat (8) @(negedge clk);
        rd_chk("w1c_pre", 8'hF8, 8'h03);
        wdata = 8'h01; we = 1'b1;
        @(negedge clk);
        we = 1'b0; din[7:0] = 8'h11;
        #2 chk("w1c_clear", rdata, 8'h02);
        repeat (5) @(negedge clk);
        rd_chk("w1c_in0_not_yet", 8'hF0, 8'h5A);
        addr = 8'hF8; wdata = 8'h01; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        rd_chk("w1c_set_wins", 8'hF8, 8'h03);
        rd_chk("w1c_in0_new", 8'hF0, 8'h11);

        @(negedge clk);
        addr = 8'hF9; wdata = 8'h02; we = 1'b1;
        @(negedge clk);
        addr = 8'hF8; wdata = 8'h03;
        @(negedge clk);
        we = 1'b0;
        rd_chk("irq_status_clr", 8'hF8, 8'h00);
        chk("irq_idle", irq, 1'b0);
`ifdef MMIO_PIO_IRQ_EN
        rd_chk("irq_mask_rd", 8'hF9, 8'h02);
`else
        rd_chk("irq_mask_rd", 8'hF9, 8'h00);
`endif
        din[7:0] = 8'h22;
        repeat (8) @(negedge clk);
        #1 chk("irq_ch0_masked", irq, 1'b0);
        rd_chk("irq_ch0_status", 8'hF8, 8'h01);
        din[15:8] = 8'h44;
        repeat (8) @(negedge clk);
`ifdef MMIO_PIO_IRQ_EN
        #1 chk("irq_ch1", irq, 1'b1);
`else
        #1 chk("irq_ch1", irq, 1'b0);
`endif
        wdata = 8'h02; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        #1 chk("irq_after_clr", irq, 1'b0);

        @(negedge clk);
        addr = 8'hF4; wdata = 8'h77; we = 1'b1;
        @(negedge clk);
        we = 1'b0; din = 16'hFFFF;
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #2 chk("rst_dout", dout, 16'h0000);
        chk("rst_irq", irq, 1'b0);
        rd_chk("rst_f0", 8'hF0, 8'h00);
        rd_chk("rst_f4", 8'hF4, 8'h00);
        rd_chk("rst_f8", 8'hF8, 8'h00);
        @(negedge clk);
        rst = 1'b0; addr = 8'hF8;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            #2 chk($sformatf("rst_status_edge%0d", e), rdata, (e < 6) ? 8'h00 : 8'h03);
        end
        rd_chk("rst_in0_after", 8'hF0, 8'hFF);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = (c == 300);
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 3))
                        0: din[ch*8 +: 8] = 8'h00;
                        1: din[ch*8 +: 8] = 8'h5A;
                        2: din[ch*8 +: 8] = 8'hA5;
                        default: din[ch*8 +: 8] = 8'hFF;
                    endcase
                end
            end
            addr      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'hF, 4'($urandom)};
            we        = ($urandom_range(0, 2) == 0);
            wdata     = 8'($urandom);
            mem_rdata = 8'($urandom);
            #2 check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
